// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port word RAM among NUM_REQ requesters.
// One transaction in flight; RAM inputs are held stable until the response completes or times out.
module ram_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int SETTLE  = 2,
   parameter int TIMEOUT = 64
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_REQ-1:0]      req,
   input  logic [NUM_REQ-1:0]      req_wr,
   input  logic [32*NUM_REQ-1:0]   req_addr,
   input  logic [32*NUM_REQ-1:0]   req_data,
   output logic [NUM_REQ-1:0]      ack,
   output logic [31:0]             rd_data,
   output logic                    err,
   output logic                    busy,
   output logic [31:0]             mem_data,
   output logic [31:0]             mem_addr,
   output logic                    mem_wr,
   input  logic                    mem_response,
   input  logic [31:0]             mem_out
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   grant_q, grant_d;
   logic [IW-1:0]   rr_q, rr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            busy_q, busy_d;
   logic            err_pend_q, err_pend_d;
   logic [31:0]     rd_data_q, rd_data_d;
   logic [31:0]     mem_data_q, mem_data_d;
   logic [31:0]     mem_addr_q, mem_addr_d;
   logic            mem_wr_q, mem_wr_d;

   logic [IW-1:0]   win;
   logic [IW:0]     cand;
   logic [IW:0]     grant_inc;

   // Scan offsets from the highest down so the smallest offset from rr_q wins.
   always_comb begin
      win  = '0;
      cand = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         cand = {1'b0, rr_q} + (IW+1)'(i);
         if (cand >= (IW+1)'(NUM_REQ)) begin
            cand = cand - (IW+1)'(NUM_REQ);
         end
         if (req[cand[IW-1:0]]) begin
            win = cand[IW-1:0];
         end
      end
   end

   assign grant_inc = {1'b0, grant_q} + (IW+1)'(1);

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      rr_d       = rr_q;
      cnt_d      = cnt_q;
      busy_d     = busy_q;
      err_pend_d = err_pend_q;
      rd_data_d  = rd_data_q;
      mem_data_d = mem_data_q;
      mem_addr_d = mem_addr_q;
      mem_wr_d   = mem_wr_q;
      case (state_q)
         S_IDLE: begin
            if (|req) begin
               grant_d    = win;
               mem_wr_d   = req_wr[win];
               mem_addr_d = req_addr[32*win +: 32];
               mem_data_d = req_data[32*win +: 32];
               busy_d     = 1'b1;
               err_pend_d = 1'b0;
               state_d    = S_ISSUE;
            end
         end
         S_ISSUE: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // A completion on the final WAIT cycle takes priority over the timeout.
            if ((cnt_q >= CW'(SETTLE - 1)) && mem_response) begin
               if (!mem_wr_q) begin
                  rd_data_d = mem_out;
               end
               state_d = S_DONE;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               err_pend_d = 1'b1;
               state_d    = S_DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DONE: begin
            rr_d    = (grant_inc == (IW+1)'(NUM_REQ)) ? '0 : grant_inc[IW-1:0];
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         grant_q    <= '0;
         rr_q       <= '0;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         err_pend_q <= 1'b0;
         rd_data_q  <= '0;
         mem_data_q <= '0;
         mem_addr_q <= '0;
         mem_wr_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         rr_q       <= rr_d;
         cnt_q      <= cnt_d;
         busy_q     <= busy_d;
         err_pend_q <= err_pend_d;
         rd_data_q  <= rd_data_d;
         mem_data_q <= mem_data_d;
         mem_addr_q <= mem_addr_d;
         mem_wr_q   <= mem_wr_d;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_ack
         assign ack[gi] = (state_q == S_DONE) && (grant_q == IW'(gi));
      end
   endgenerate

   assign err      = (state_q == S_DONE) && err_pend_q;
   assign busy     = busy_q;
   assign rd_data  = rd_data_q;
   assign mem_data = mem_data_q;
   assign mem_addr = mem_addr_q;
   assign mem_wr   = mem_wr_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: small RAM model, hand-computed expectations.
module tb_ram_arbiter;

   localparam int NUM_REQ = 2;
   localparam int SETTLE  = 2;
   localparam int TIMEOUT = 64;
   localparam int LAT     = SETTLE + 2;
   localparam int TO_LAT  = TIMEOUT + 2;
   localparam int MAXWAIT = 200;

   logic                  clk;
   logic                  rst_n;
   logic [NUM_REQ-1:0]    req;
   logic [NUM_REQ-1:0]    req_wr;
   logic [32*NUM_REQ-1:0] req_addr;
   logic [32*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]    ack;
   logic [31:0]           rd_data;
   logic                  err;
   logic                  busy;
   logic [31:0]           mem_data;
   logic [31:0]           mem_addr;
   logic                  mem_wr;
   logic                  mem_response;
   logic [31:0]           mem_out;

   logic [31:0]           ram [0:15];
   logic                  resp_en;

   int checks = 0;
   int errors = 0;

   ram_arbiter #(
      .NUM_REQ (NUM_REQ),
      .SETTLE  (SETTLE),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req          (req),
      .req_wr       (req_wr),
      .req_addr     (req_addr),
      .req_data     (req_data),
      .ack          (ack),
      .rd_data      (rd_data),
      .err          (err),
      .busy         (busy),
      .mem_data     (mem_data),
      .mem_addr     (mem_addr),
      .mem_wr       (mem_wr),
      .mem_response (mem_response),
      .mem_out      (mem_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model: responds when enabled, writes on posedge while wr is held.
   assign mem_response = resp_en;
   assign mem_out      = ram[mem_addr[3:0]];
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) ram[i] <= 32'h0;
         ram[5] <= 32'hDEAD_BEEF;
         ram[3] <= 32'hCAFE_F00D;
      end else if (mem_wr && resp_en) begin
         ram[mem_addr[3:0]] <= mem_data;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // Called right after a negedge; returns cycles from the IDLE sample edge to the ack.
   task automatic run_txn(input int idx, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, output int lat, output logic [NUM_REQ-1:0] ack_seen);
      int n;
      req_wr[idx]            = wr;
      req_addr[32*idx +: 32] = addr;
      req_data[32*idx +: 32] = data;
      req[idx]               = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (ack == '0 && n < MAXWAIT);
      lat      = n;
      ack_seen = ack;
      req[idx] = 1'b0;
      $display("txn req=%0d wr=%0b addr=%08h data=%08h lat=%0d ack=%b rd_data=%08h err=%0b",
               idx, wr, addr, data, lat, ack_seen, rd_data, err);
   endtask

   initial begin
      int                 lat;
      logic [NUM_REQ-1:0] a;
      logic [NUM_REQ-1:0] exp_ack;
      logic [31:0]        exp_rd;
      int                 n;
      logic               any_ack;

      rst_n    = 1'b0;
      req      = '0;
      req_wr   = '0;
      req_addr = '0;
      req_data = '0;
      resp_en  = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      check("rst_ack", 32'(ack), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_err", 32'(err), 32'h0);
      check("rst_rd_data", rd_data, 32'h0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_mem_wr", 32'(mem_wr), 32'h0);

      // Single read by requester 0.
      run_txn(0, 1'b0, 32'd5, 32'h0, lat, a);
      check("rd0_ack", 32'(a), 32'h1);
      check("rd0_data", rd_data, 32'hDEAD_BEEF);
      check("rd0_err", 32'(err), 32'h0);
      check("rd0_lat", 32'(lat), 32'(LAT));
      @(negedge clk);
      check("rd0_ack_pulse", 32'(ack), 32'h0);
      check("rd0_busy_drop", 32'(busy), 32'h0);

      // Write then read back by requester 1.
      run_txn(1, 1'b1, 32'd9, 32'h1234_5678, lat, a);
      check("wr1_ack", 32'(a), 32'h2);
      check("wr1_rd_held", rd_data, 32'hDEAD_BEEF);
      check("wr1_lat", 32'(lat), 32'(LAT));
      @(negedge clk);
      run_txn(1, 1'b0, 32'd9, 32'h0, lat, a);
      check("rd1_ack", 32'(a), 32'h2);
      check("rd1_data", rd_data, 32'h1234_5678);
      @(negedge clk);

      // Contention: both held, expect strict alternation starting at requester 0.
      req_wr   = '0;
      req_addr = {32'd9, 32'd5};
      req      = 2'b11;
      for (int k = 0; k < 4; k++) begin
         exp_ack = (k % 2 == 0) ? 2'b01 : 2'b10;
         exp_rd  = (k % 2 == 0) ? 32'hDEAD_BEEF : 32'h1234_5678;
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (ack == '0 && n < MAXWAIT);
         $display("txn contention k=%0d ack=%b rd_data=%08h wait=%0d", k, ack, rd_data, n);
         check("cont_ack", 32'(ack), 32'(exp_ack));
         check("cont_rd_data", rd_data, exp_rd);
         if (k == 3) req = '0;
         @(negedge clk);
         check("cont_busy_gap", 32'(busy), 32'h0);
         if (k < 3) begin
            @(negedge clk);
            check("cont_busy_regrant", 32'(busy), 32'h1);
         end
      end

      // Identical consecutive reads.
      run_txn(0, 1'b0, 32'd3, 32'h0, lat, a);
      check("rep1_ack", 32'(a), 32'h1);
      check("rep1_data", rd_data, 32'hCAFE_F00D);
      check("rep1_lat", 32'(lat), 32'(LAT));
      @(negedge clk);
      run_txn(0, 1'b0, 32'd3, 32'h0, lat, a);
      check("rep2_ack", 32'(a), 32'h1);
      check("rep2_data", rd_data, 32'hCAFE_F00D);
      check("rep2_lat", 32'(lat), 32'(LAT));
      @(negedge clk);

      // Timeout with response stuck low.
      resp_en = 1'b0;
      run_txn(1, 1'b0, 32'd5, 32'h0, lat, a);
      check("to_ack", 32'(a), 32'h2);
      check("to_err", 32'(err), 32'h1);
      check("to_rd_held", rd_data, 32'hCAFE_F00D);
      check("to_lat", 32'(lat), 32'(TO_LAT));
      resp_en = 1'b1;
      @(negedge clk);
      check("to_err_pulse", 32'(err), 32'h0);

      // Asynchronous reset in the middle of WAIT.
      req_wr[0]         = 1'b0;
      req_addr[31:0]    = 32'd5;
      req[0]            = 1'b1;
      repeat (2) @(negedge clk);
      check("mid_busy", 32'(busy), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_busy", 32'(busy), 32'h0);
      check("mid_rst_ack", 32'(ack), 32'h0);
      check("mid_rst_rd_data", rd_data, 32'h0);
      check("mid_rst_mem_addr", mem_addr, 32'h0);
      req = '0;
      @(negedge clk);
      rst_n   = 1'b1;
      any_ack = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (ack != '0) any_ack = 1'b1;
      end
      check("mid_rst_no_ack", 32'(any_ack), 32'h0);

      // Recovery after reset: requester 0 re-arbitrates.
      run_txn(0, 1'b0, 32'd5, 32'h0, lat, a);
      check("post_rst_ack", 32'(a), 32'h1);
      check("post_rst_data", rd_data, 32'hDEAD_BEEF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
